sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001: Parameter SPR_W, default 80, sprite width in pixels.
REQ-002: Parameter SPR_H, default 120, sprite height in pixels.
REQ-003: Parameter NUM_SPR, default 3, number of sprite ROMs (rock, scissor, paper).
REQ-004: Parameter ROM_LAT, default 1, ROM read latency in cycles (range 1-3).
REQ-005: Parameter SCR_W / SCR_H, default 160 / 120, screen size for clipping.
REQ-006: CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-007: reset  in  1  asynchronous, active-high reset.
REQ-008: start  in  1  one-cycle request to draw a sprite.
REQ-009: sprite_sel  in  2  ROM index, sampled at accepted start.
REQ-010: x0 / y0  in  8 / 7  screen origin of the sprite's top-left pixel, sampled at start.
REQ-011: fg_colour / bg_colour  in  3 / 3  colours for ROM bit 0 / ROM bit 1, sampled at start.
REQ-012: transparent  in  1  when 1, bg pixels are not plotted; sampled at start.
REQ-013: rom_addr  out  15  shared address to all sprite ROMs.
REQ-014: rom_q  in  NUM_SPR  one data bit per ROM, valid ROM_LAT cycles after rom_addr.
REQ-015: x / y / colour / plot  out  8 / 7 / 3 / 1  pixel write port to vga_adapter.
REQ-016: busy  out  1  high from accepted start until done.
REQ-017: done  out  1  one-cycle pulse when the final pixel has been issued.

Function
REQ-018: States IDLE, SCAN, DRAIN, FIN; reset state IDLE.
REQ-019: IDLE -> SCAN on start=1; inputs latched that cycle; col=row=0.
REQ-020: start while busy=1 is ignored; latched values do not change.
REQ-021: SCAN issues one address per cycle: rom_addr = row*SPR_W + col, computed with shift-add when SPR_W is 80 or 160, no truncation below 15 bits.
REQ-022: col increments each SCAN cycle; at col=SPR_W-1 col wraps to 0 and row increments.
REQ-023: Issuing address at row=SPR_H-1, col=SPR_W-1 moves SCAN -> DRAIN.
REQ-024: DRAIN lasts exactly ROM_LAT cycles, then FIN; FIN asserts done for one cycle and returns to IDLE.
REQ-025: Screen coords (x0+col, y0+row) and a valid bit travel in a ROM_LAT-deep pipeline aligned with rom_q.
REQ-026: Pipeline output: colour = fg_colour if selected rom_q bit is 0, else bg_colour.
REQ-027: plot = 1 iff pipeline valid AND (x0+col) < SCR_W AND (y0+row) < SCR_H AND NOT (transparent AND bit=1); sums computed one bit wider (no wrap).
REQ-028: sprite_sel >= NUM_SPR selects ROM NUM_SPR-1.
REQ-029: Total start-to-done latency = SPR_W*SPR_H + ROM_LAT + 1 cycles; plot never asserted outside SCAN/DRAIN.
REQ-030: busy = 1 in SCAN, DRAIN, FIN; 0 in IDLE.

Reset
REQ-031: reset=1 forces IDLE immediately regardless of state; rom_addr=0, x=0, y=0, colour=0, plot=0, busy=0, done=0, pipeline valid bits cleared.
REQ-032: Reset mid-SCAN abandons the sprite; no done pulse; next start begins from row=col=0.

Structure
REQ-033: Shared package holds state encoding, SCR_W/SCR_H constants and colour constants (BLACK 000, GREEN 010, WHITE 111).
REQ-034: One sub-module, blit_pipe: ROM_LAT-deep shift register of {x, y, valid}.
REQ-035: Address arithmetic stays in-module; image_translator is not reused (different stride).

Verification
REQ-036: ROM_LAT=1, x0=0,y0=0, sel=0, rom all 0 -> 9600 plots, all colour=fg, first plot (0,0) at cycle 2 after start, done at cycle 9602.
REQ-037: x0=120, y0=0, SPR_W=80 -> plots only for x 120..159; no plot with col>=40; done timing unchanged.
REQ-038: transparent=1, rom_q bit pattern alternating 0/1 per address -> plot toggles every cycle, colour=fg on plotted pixels.
REQ-039: start pulsed again at cycle 100 of SCAN with different sel/x0 -> ignored; output continues for original sprite.
REQ-040: reset asserted at cycle 500 of SCAN -> plot, busy 0 same cycle, no done; new start redraws from (x0,y0).
REQ-041: ROM_LAT=3 -> rom_addr to plot offset exactly 3 cycles; DRAIN 3 cycles; last pixel (79,119) plotted before done.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter: FSM encoding, default screen
// size, colour constants and the sprite-ROM address helper.
package sprite_blitter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam int SCR_W_DEF = 160;
   localparam int SCR_H_DEF = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] WHITE = 3'b111;

   localparam int ADDR_W = 15;

   // Linear ROM address row*stride + col. The two common strides use a
   // shift-add so no multiplier is needed; everything stays 15 bits wide.
   function automatic logic [ADDR_W-1:0] sprite_addr(
      input logic [ADDR_W-1:0] row,
      input logic [ADDR_W-1:0] col,
      input int                stride
   );
      logic [ADDR_W-1:0] a;
      case (stride)
         80:      a = (row << 6) + (row << 4) + col;
         160:     a = (row << 7) + (row << 5) + col;
         default: a = row * ADDR_W'(stride) + col;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/blit_pipe.sv
// Delay line carrying the screen coordinates and a valid flag alongside the
// sprite ROM read, so they emerge in the same cycle as the ROM data.
module blit_pipe #(
   parameter int DEPTH = 1,
   parameter int XW    = 9,
   parameter int YW    = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [XW-1:0] x_i,
   input  logic [YW-1:0] y_i,
   input  logic          valid_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          valid_o
);

   localparam int SW = XW + YW + 1;

   logic [DEPTH-1:0][SW-1:0] stage_q;
   logic [DEPTH-1:0][SW-1:0] stage_d;

   // Each stage loads from its predecessor; stage 0 loads the new sample.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_d[gi] = {x_i, y_i, valid_i};
         end else begin : g_body
            assign stage_d[gi] = stage_q[gi-1];
         end
      end
   endgenerate

   // Shift every cycle; reset empties the line so no stale pixel is plotted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign {x_o, y_o, valid_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans one sprite ROM in raster order and streams the pixels
// to a VGA pixel-write port, with screen clipping and optional transparency.
module sprite_blitter
   import sprite_blitter_pkg::*;
#(
   parameter int SPR_W   = 80,
   parameter int SPR_H   = 120,
   parameter int NUM_SPR = 3,
   parameter int ROM_LAT = 1,
   parameter int SCR_W   = SCR_W_DEF,
   parameter int SCR_H   = SCR_H_DEF
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         sprite_sel,
   input  logic [7:0]         x0,
   input  logic [6:0]         y0,
   input  logic [2:0]         fg_colour,
   input  logic [2:0]         bg_colour,
   input  logic               transparent,
   output logic [14:0]        rom_addr,
   input  logic [NUM_SPR-1:0] rom_q,
   output logic [7:0]         x,
   output logic [6:0]         y,
   output logic [2:0]         colour,
   output logic               plot,
   output logic               busy,
   output logic               done
);

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   // Coordinate sums are one bit wider than the screen ports so an
   // off-screen pixel can never wrap back onto the screen.
   localparam int XW = 9;
   localparam int YW = 8;

   state_e         state_q, state_d;
   logic [CW-1:0]  col_q, col_d;
   logic [RW-1:0]  row_q, row_d;
   logic [1:0]     drain_q, drain_d;
   logic [1:0]     sel_q, sel_d;
   logic [7:0]     x0_q, x0_d;
   logic [6:0]     y0_q, y0_d;
   logic [2:0]     fg_q, fg_d;
   logic [2:0]     bg_q, bg_d;
   logic           transp_q, transp_d;

   logic           last_col;
   logic           last_row;
   logic [XW-1:0]  pipe_x_in, pipe_x;
   logic [YW-1:0]  pipe_y_in, pipe_y;
   logic           pipe_v_in, pipe_v;
   logic           pix_bit;

   assign last_col = (col_q == CW'(SPR_W - 1));
   assign last_row = (row_q == RW'(SPR_H - 1));

   // Next-state, scan counters and sprite parameter capture.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      drain_d  = drain_q;
      sel_d    = sel_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      fg_d     = fg_q;
      bg_d     = bg_q;
      transp_d = transp_q;
      busy     = (state_q != IDLE);
      done     = (state_q == FIN);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SCAN;
               col_d    = '0;
               row_d    = '0;
               x0_d     = x0;
               y0_d     = y0;
               fg_d     = fg_colour;
               bg_d     = bg_colour;
               transp_d = transparent;
               // Out-of-range selections fall back to the last ROM.
               if (int'(sprite_sel) >= NUM_SPR) begin
                  sel_d = 2'(NUM_SPR - 1);
               end else begin
                  sel_d = sprite_sel;
               end
            end
         end
         SCAN: begin
            if (last_col) begin
               col_d = '0;
               if (last_row) begin
                  // Counters park at zero so the idle address is 0.
                  row_d   = '0;
                  drain_d = '0;
                  state_d = DRAIN;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         DRAIN: begin
            // Wait for the final ROM reads to leave the pipeline.
            if (drain_q == 2'(ROM_LAT - 1)) begin
               state_d = FIN;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Scan counters and the parameters captured when a draw is accepted.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         col_q    <= '0;
         row_q    <= '0;
         drain_q  <= '0;
         sel_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         fg_q     <= BLACK;
         bg_q     <= BLACK;
         transp_q <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         drain_q  <= drain_d;
         sel_q    <= sel_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         fg_q     <= fg_d;
         bg_q     <= bg_d;
         transp_q <= transp_d;
      end
   end

   assign rom_addr = sprite_addr(ADDR_W'(row_q), ADDR_W'(col_q), SPR_W);

   assign pipe_x_in = XW'(x0_q) + XW'(col_q);
   assign pipe_y_in = YW'(y0_q) + YW'(row_q);
   assign pipe_v_in = (state_q == SCAN);

   blit_pipe #(
      .DEPTH (ROM_LAT),
      .XW    (XW),
      .YW    (YW)
   ) u_pipe (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .x_i     (pipe_x_in),
      .y_i     (pipe_y_in),
      .valid_i (pipe_v_in),
      .x_o     (pipe_x),
      .y_o     (pipe_y),
      .valid_o (pipe_v)
   );

   // Pick the data bit of the selected ROM.
   always_comb begin
      pix_bit = 1'b0;
      for (int i = 0; i < NUM_SPR; i++) begin
         if (sel_q == 2'(i)) begin
            pix_bit = rom_q[i];
         end
      end
   end

   assign x      = pipe_x[7:0];
   assign y      = pipe_y[6:0];
   assign colour = pix_bit ? bg_q : fg_q;
   assign plot   = pipe_v
                   && (pipe_x < XW'(SCR_W))
                   && (pipe_y < YW'(SCR_H))
                   && !(transp_q && pix_bit);

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised scoreboard bench for sprite_blitter with a behavioural ROM and
// a raster-order pixel model.
module tb_sprite_blitter;

   localparam int SPR_W   = 80;
   localparam int SPR_H   = 120;
   localparam int NUM_SPR = 3;
   localparam int ROM_LAT = 3;
   localparam int SCR_W   = 160;
   localparam int SCR_H   = 120;
   localparam int NPIX    = SPR_W * SPR_H;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [1:0]         sprite_sel = '0;
   logic [7:0]         x0 = '0;
   logic [6:0]         y0 = '0;
   logic [2:0]         fg_colour = '0;
   logic [2:0]         bg_colour = '0;
   logic               transparent = 1'b0;
   logic [14:0]        rom_addr;
   logic [NUM_SPR-1:0] rom_q;
   logic [7:0]         x;
   logic [6:0]         y;
   logic [2:0]         colour;
   logic               plot;
   logic               busy;
   logic               done;

   sprite_blitter #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .NUM_SPR (NUM_SPR),
      .ROM_LAT (ROM_LAT),
      .SCR_W   (SCR_W),
      .SCR_H   (SCR_H)
   ) dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .start       (start),
      .sprite_sel  (sprite_sel),
      .x0          (x0),
      .y0          (y0),
      .fg_colour   (fg_colour),
      .bg_colour   (bg_colour),
      .transparent (transparent),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .busy        (busy),
      .done        (done)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural sprite ROMs with ROM_LAT cycles of read latency.
   bit                 rom_mem [NUM_SPR][NPIX];
   logic [NUM_SPR-1:0] rq [ROM_LAT] = '{default: '0};

   function automatic logic [NUM_SPR-1:0] rom_read(input logic [14:0] a);
      logic [NUM_SPR-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SPR; i++)
         if (int'(a) < NPIX) r[i] = rom_mem[i][int'(a)];
      return r;
   endfunction

   always @(posedge clk) begin
      rq[0] <= rom_read(rom_addr);
      for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
   end
   assign rom_q = rq[ROM_LAT-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input bit ok, input string name, input string detail);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   typedef struct {
      int px;
      int py;
      int col;
      int cyc;
   } pix_t;

   pix_t exp_q[$];
   int   done_q[$];
   int   done_count = 0;

   // Reference model: raster scan of the sprite, expected plot cycle for
   // pixel p is start cycle + 1 + ROM_LAT + p, done after all pixels.
   task automatic model(input int s0, input int sel, input int xo, input int yo,
                        input int fg, input int bg, input int tr);
      int s;
      s = (sel >= NUM_SPR) ? NUM_SPR - 1 : sel;
      for (int r = 0; r < SPR_H; r++) begin
         for (int c = 0; c < SPR_W; c++) begin
            int  p;
            int  xs;
            int  ys;
            bit  b;
            p  = r * SPR_W + c;
            b  = rom_mem[s][p];
            xs = xo + c;
            ys = yo + r;
            if (xs < SCR_W && ys < SCR_H && !(tr != 0 && b))
               exp_q.push_back('{xs, ys, b ? bg : fg, s0 + 1 + ROM_LAT + p});
         end
      end
      done_q.push_back(s0 + NPIX + ROM_LAT + 1);
   endtask

   // Monitor: every plot and every done is popped against the model.
   always @(negedge clk) begin
      if (plot) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_plot",
                $sformatf("got plot at (%0d,%0d) cyc %0d, required no plot", x, y, cyc));
         end else begin
            pix_t e;
            e = exp_q.pop_front();
            chk(int'(x) == e.px && int'(y) == e.py && int'(colour) == e.col && cyc == e.cyc,
                "pixel",
                $sformatf("got (%0d,%0d) colour %0d at cyc %0d, required (%0d,%0d) colour %0d at cyc %0d",
                          x, y, colour, cyc, e.px, e.py, e.col, e.cyc));
         end
      end
      if (done) begin
         done_count++;
         if (done_q.size() == 0) begin
            chk(1'b0, "unexpected_done", $sformatf("got done at cyc %0d, required none", cyc));
         end else begin
            int d;
            d = done_q.pop_front();
            chk(cyc == d, "done_cycle", $sformatf("got done at cyc %0d, required cyc %0d", cyc, d));
         end
      end
   end

   task automatic fill_rom(input int mode);
      for (int i = 0; i < NUM_SPR; i++)
         for (int p = 0; p < NPIX; p++)
            case (mode)
               0:       rom_mem[i][p] = 1'b0;
               1:       rom_mem[i][p] = (p % 2) == 1;
               default: rom_mem[i][p] = $urandom_range(0, 1) == 1;
            endcase
   endtask

   // One draw. mid_at > 0 pulses a conflicting start that many cycles in;
   // rst_at > 0 resets the blitter that many cycles in and abandons the draw.
   task automatic draw(input int sel, input int xo, input int yo, input int fg,
                       input int bg, input int tr, input int mid_at, input int rst_at);
      int s0;
      int dc0;
      int t;
      int nexp;
      @(negedge clk); #1;
      sprite_sel  = 2'(sel);
      x0          = 8'(xo);
      y0          = 7'(yo);
      fg_colour   = 3'(fg);
      bg_colour   = 3'(bg);
      transparent = tr[0];
      start       = 1'b1;
      s0          = cyc;
      dc0         = done_count;
      model(s0, sel, xo, yo, fg, bg, tr);
      nexp        = exp_q.size();
      @(negedge clk); #1;
      start       = 1'b0;
      chk(busy == 1'b1, "busy_after_start", $sformatf("got %0b, required 1", busy));
      // Scramble the inputs; the draw must use the captured values.
      sprite_sel  = 2'($urandom_range(0, 3));
      x0          = 8'($urandom);
      y0          = 7'($urandom);
      fg_colour   = 3'($urandom);
      bg_colour   = 3'($urandom);
      transparent = 1'($urandom);

      if (mid_at > 0) begin
         while (cyc < s0 + mid_at) @(negedge clk);
         #1;
         sprite_sel  = 2'((sel + 1) % 3);
         x0          = 8'(xo + 5);
         fg_colour   = 3'(bg);
         start       = 1'b1;
         @(negedge clk); #1;
         start       = 1'b0;
      end

      if (rst_at > 0) begin
         while (cyc < s0 + rst_at) @(negedge clk);
         #1;
         rst = 1'b1;
         #1;
         chk(plot == 1'b0, "reset_plot", $sformatf("got %0b, required 0", plot));
         chk(busy == 1'b0, "reset_busy", $sformatf("got %0b, required 0", busy));
         chk(rom_addr == 15'd0 && x == 8'd0 && y == 7'd0 && colour == 3'd0,
             "reset_outputs", $sformatf("got addr %0d x %0d y %0d colour %0d, required all 0",
                                        rom_addr, x, y, colour));
         exp_q.delete();
         done_q.delete();
         @(negedge clk); #1;
         rst = 1'b0;
         repeat (40) @(negedge clk);
         #1;
         chk(done_count == dc0, "no_done_after_reset",
             $sformatf("got %0d done pulses, required 0", done_count - dc0));
         chk(busy == 1'b0, "idle_after_reset", $sformatf("got %0b, required 0", busy));
         $display("draw sel=%0d x0=%0d y0=%0d tr=%0d abandoned by reset at cycle %0d", sel, xo, yo, tr, rst_at);
         return;
      end

      t = 0;
      while (done_count == dc0 && t < NPIX + ROM_LAT + 20) begin
         @(negedge clk);
         t++;
      end
      chk(done_count != dc0, "done_timeout", $sformatf("got no done within %0d cycles, required one", t));
      @(negedge clk); #1;
      chk(exp_q.size() == 0, "all_pixels_plotted",
          $sformatf("got %0d pixels missing, required 0", exp_q.size()));
      chk(busy == 1'b0, "busy_after_done", $sformatf("got %0b, required 0", busy));
      exp_q.delete();
      done_q.delete();
      $display("draw sel=%0d x0=%0d y0=%0d fg=%0d bg=%0d tr=%0d mid_start=%0d expected_plots=%0d",
               sel, xo, yo, fg, bg, tr, mid_at, nexp);
   endtask

   function automatic int other_colour(input int c);
      return (c + int'($urandom_range(1, 7))) % 8;
   endfunction

   initial begin
      int fg;
      repeat (3) @(negedge clk);
      #1;
      chk(busy == 1'b0 && done == 1'b0 && plot == 1'b0, "reset_state_ctrl",
          $sformatf("got busy %0b done %0b plot %0b, required 0 0 0", busy, done, plot));
      chk(rom_addr == 15'd0 && x == 8'd0 && y == 7'd0 && colour == 3'd0, "reset_state_data",
          $sformatf("got addr %0d x %0d y %0d colour %0d, required all 0", rom_addr, x, y, colour));
      rst = 1'b0;
      @(negedge clk); #1;
      chk(busy == 1'b0, "idle_after_reset_release", $sformatf("got %0b, required 0", busy));

      // Blank ROM at the origin: every pixel on screen in foreground.
      fill_rom(0);
      draw(0, 0, 0, 3'b010, 3'b111, 0, -1, -1);

      // Right-edge clipping: only columns 0..39 land on screen.
      fill_rom(2);
      fg = int'($urandom_range(0, 7));
      draw(0, 120, 0, fg, other_colour(fg), 0, -1, -1);

      // Alternating ROM with transparency: every other pixel plotted.
      fill_rom(1);
      fg = int'($urandom_range(0, 7));
      draw(1, 0, 0, fg, other_colour(fg), 1, -1, -1);

      // Conflicting start mid-scan is ignored.
      fill_rom(2);
      fg = int'($urandom_range(0, 7));
      draw(2, 30, 20, fg, other_colour(fg), 0, 100, -1);

      // Reset mid-scan, then redraw the same sprite from the start.
      fg = int'($urandom_range(0, 7));
      draw(1, 7, 3, fg, other_colour(fg), 0, -1, 500);
      draw(1, 7, 3, fg, other_colour(fg), 0, -1, -1);

      // Out-of-range selection with bottom clipping and transparency.
      fill_rom(2);
      fg = int'($urandom_range(0, 7));
      draw(3, 50, 100, fg, other_colour(fg), 1, -1, -1);

      // Fully random draw.
      fill_rom(2);
      fg = int'($urandom_range(0, 7));
      draw(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           fg, other_colour(fg), int'($urandom_range(0, 1)), -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
